// File: rtl/mm_job_arbiter_if.sv
// rtl/mm_job_arbiter_if.sv - requester and multiply-unit handshake bundle for mm_job_arbiter
`timescale 1ns/1ps
interface mm_job_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 32
) ();
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*AW-1:0]      req_addr;
  logic [NREQ-1:0]         req_mode;
  logic [NREQ-1:0]         rsp_done;
  logic [NREQ-1:0]         rsp_err;
  logic                    mm_start;
  logic [AW-1:0]           mm_addr;
  logic                    mm_mode;
  logic                    mm_done;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] owner;

  modport slave (
    input  req_valid, req_addr, req_mode, mm_done,
    output req_ready, rsp_done, rsp_err, mm_start, mm_addr, mm_mode, busy, owner
  );

  modport master (
    output req_valid, req_addr, req_mode, mm_done,
    input  req_ready, rsp_done, rsp_err, mm_start, mm_addr, mm_mode, busy, owner
  );
endinterface

// File: rtl/mm_job_arbiter.sv
// rtl/mm_job_arbiter.sv - round-robin job arbiter for the shared 3x3 systolic multiply unit
`timescale 1ns/1ps
module mm_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  mm_job_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_grant_q, last_grant_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              mode_q, mode_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   rsp_done_q, rsp_done_d;
  logic [NREQ-1:0]   rsp_err_q, rsp_err_d;

  logic [IW-1:0]     grant, cand;
  logic              any_valid;
  logic [NREQ-1:0]   ready;
  logic [CW-1:0]     cnt_inc;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Search starts one past the last winner and wraps, so every requester waits at most NREQ-1 jobs.
  always_comb begin
    grant     = '0;
    cand      = last_grant_q;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!any_valid && bus.req_valid[cand]) begin
        grant     = cand;
        any_valid = 1'b1;
      end
    end
  end

  // cnt_q counts completed WAIT cycles; cnt_inc includes the current one.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    rsp_done_d   = '0;
    rsp_err_d    = '0;
    ready        = '0;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          ready        = onehot(grant);
          addr_d       = bus.req_addr[grant*AW +: AW];
          mode_d       = bus.req_mode[grant];
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // Completion takes precedence over a timeout landing on the same cycle.
        if (bus.mm_done) begin
          rsp_done_d = onehot(owner_q);
          state_d    = S_DRAIN;
        end else if (cnt_inc == CNT_MAX) begin
          rsp_done_d = onehot(owner_q);
          rsp_err_d  = onehot(owner_q);
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!bus.mm_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= LAST_IDX;
      owner_q      <= '0;
      addr_q       <= '0;
      mode_q       <= 1'b0;
      cnt_q        <= '0;
      rsp_done_q   <= '0;
      rsp_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      rsp_done_q   <= rsp_done_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_done  = rsp_done_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mm_start  = (state_q == S_ISSUE);
  assign bus.mm_addr   = addr_q;
  assign bus.mm_mode   = mode_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.owner     = owner_q;
endmodule
